// File: rtl/rxll_rd_ctrl.sv
// ---------------------------------------------------------------------------
// rxll_rd_ctrl -- read-side sequencer for the SATA receive link-layer FIFO.
//
// Drains 36-bit FWFT FIFO words ([31:0] data, [32] SOF, [33] ERR, [34] EOF,
// [35] reserved) into the DMA write port one burst at a time, and reports the
// length and error status of every closed frame. Oversized, aborted and
// SOF-truncated frames are flagged bad; the undeliverable tail of an oversized
// or aborted frame is popped and discarded up to its EOF word.
//
// Ports
//   rd_clk, rst    clock; synchronous active-high reset
//   enable         allows new bursts to be requested
//   abort          1-cycle pulse: discard the rest of the current frame
//   fifo_*         FWFT FIFO read side (head word, empty, count, EOF queued, pop)
//   dma_req/gnt    burst request / 1-cycle grant
//   dma_data/valid/ready/last   burst write data handshake
//   frm_done       1-cycle pulse when a frame closes
//   frm_len/err    length (dwords, incl. EOF word) and error of the last frame
// ---------------------------------------------------------------------------
module rxll_rd_ctrl #(
    parameter int C_BURST     = 16,
    parameter int C_MAX_WORDS = 2049
) (
    input  logic        rd_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        abort,
    input  logic [35:0] fifo_rd_do,
    input  logic        fifo_empty,
    input  logic [9:0]  fifo_count,
    input  logic        fifo_eof_rdy,
    output logic        fifo_rd_en,
    output logic        dma_req,
    input  logic        dma_gnt,
    output logic [31:0] dma_data,
    output logic        dma_valid,
    input  logic        dma_ready,
    output logic        dma_last,
    output logic        frm_done,
    output logic [15:0] frm_len,
    output logic        frm_err
);

    localparam int              BW          = (C_BURST > 1) ? $clog2(C_BURST) : 1;
    localparam logic [BW-1:0]   BCNT_LAST   = BW'(C_BURST - 1);
    localparam logic [9:0]      BURST_WORDS = 10'(C_BURST);
    localparam logic [15:0]     MAX_M1      = 16'(C_MAX_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        FLUSH,
        DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   bcnt;        // beats popped in the current burst
    logic [15:0]     flen;        // words popped in the current frame (saturating)
    logic            ferr;        // sticky error for the current frame
    logic            abort_pend;  // abort seen in XFER with no beat accepted yet

    logic            head_sof;
    logic            head_err;
    logic            head_eof;
    logic            oversize;
    logic            abort_now;
    logic            mid_sof;
    logic            beat;
    logic [15:0]     flen_inc;
    logic            unused_rsvd;

    assign head_sof    = fifo_rd_do[32];
    assign head_err    = fifo_rd_do[33];
    assign head_eof    = fifo_rd_do[34];
    assign unused_rsvd = fifo_rd_do[35];

    // The word that would make the frame C_MAX_WORDS long without being its EOF.
    assign oversize  = (flen == MAX_M1) && !head_eof;
    assign abort_now = abort || abort_pend;
    assign flen_inc  = (flen == 16'hFFFF) ? flen : flen + 16'd1;
    assign beat      = dma_valid && dma_ready;

    // The DMA handshake must follow the FWFT head in the same cycle, so these
    // outputs are decoded combinationally from the registered state.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mid_sof    = 1'b0;
        dma_valid  = 1'b0;
        dma_last   = 1'b0;
        fifo_rd_en = 1'b0;
        dma_data   = '0;
        if (state == XFER) begin
            // A SOF on a non-first word closes the open frame; the SOF word
            // stays at the FIFO head to start the next frame.
            mid_sof    = !fifo_empty && head_sof && (flen != 16'd0);
            dma_valid  = !fifo_empty && !mid_sof;
            dma_last   = dma_valid && ((bcnt == BCNT_LAST) || head_eof || oversize || abort_now);
            fifo_rd_en = dma_valid && dma_ready;
            dma_data   = fifo_rd_do[31:0];
        end else if (state == FLUSH) begin
            fifo_rd_en = !fifo_empty;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state      <= IDLE;
            bcnt       <= '0;
            flen       <= '0;
            ferr       <= 1'b0;
            abort_pend <= 1'b0;
            dma_req    <= 1'b0;
            frm_done   <= 1'b0;
            frm_len    <= '0;
            frm_err    <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && ((fifo_count >= BURST_WORDS) || fifo_eof_rdy)) begin
                        state   <= REQ;
                        dma_req <= 1'b1;
                    end
                end

                REQ: begin
                    // abort wins over a simultaneous grant
                    if (abort) begin
                        state   <= FLUSH;
                        dma_req <= 1'b0;
                        ferr    <= 1'b1;
                    end else if (dma_gnt) begin
                        state   <= XFER;
                        dma_req <= 1'b0;
                    end
                end

                XFER: begin
                    ferr <= ferr | abort | mid_sof | (beat && ((head_eof && head_err) || oversize));
                    if (mid_sof) begin
                        bcnt       <= '0;
                        abort_pend <= 1'b0;
                        state      <= DONE;
                    end else if (beat) begin
                        flen <= flen_inc;
                        if (dma_last) begin
                            bcnt       <= '0;
                            abort_pend <= 1'b0;
                            if (head_eof)
                                state <= DONE;
                            else if (oversize || abort_now)
                                state <= FLUSH;
                            else
                                state <= IDLE;   // frame continues in a later burst
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;      // force dma_last on the next beat
                    end
                end

                FLUSH: begin
                    if (!fifo_empty) begin
                        flen <= flen_inc;
                        if (head_eof)
                            state <= DONE;
                    end
                end

                DONE: begin
                    frm_done <= 1'b1;
                    frm_len  <= flen;
                    frm_err  <= ferr;
                    flen     <= '0;
                    ferr     <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rxll_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rxll_rd_ctrl -- randomized self-checking bench for rxll_rd_ctrl.
// A queue models the FWFT FIFO, a small DMA model grants bursts and applies
// back-pressure, and a frame-level reference model derives the expected beat
// stream and frame reports from the word stream pushed into the FIFO.
// ---------------------------------------------------------------------------
module tb_rxll_rd_ctrl;

    localparam int C_BURST = 16;
    localparam int C_MAX   = 2049;

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    typedef struct packed { logic [15:0] len;  logic err;  } frame_t;

    logic        rd_clk = 1'b0;
    logic        rst, enable, abort;
    logic [35:0] fifo_rd_do;
    logic        fifo_empty;
    logic [9:0]  fifo_count;
    logic        fifo_eof_rdy;
    logic        fifo_rd_en;
    logic        dma_req, dma_gnt;
    logic [31:0] dma_data;
    logic        dma_valid, dma_ready, dma_last;
    logic        frm_done;
    logic [15:0] frm_len;
    logic        frm_err;

    rxll_rd_ctrl #(.C_BURST(C_BURST), .C_MAX_WORDS(C_MAX)) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .enable      (enable),
        .abort       (abort),
        .fifo_rd_do  (fifo_rd_do),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .fifo_eof_rdy(fifo_eof_rdy),
        .fifo_rd_en  (fifo_rd_en),
        .dma_req     (dma_req),
        .dma_gnt     (dma_gnt),
        .dma_data    (dma_data),
        .dma_valid   (dma_valid),
        .dma_ready   (dma_ready),
        .dma_last    (dma_last),
        .frm_done    (frm_done),
        .frm_len     (frm_len),
        .frm_err     (frm_err)
    );

    always #5 rd_clk = ~rd_clk;

    logic [35:0] fifo_q[$];
    logic [35:0] stim_q[$];
    beat_t       got_beats[$], exp_beats[$];
    frame_t      got_frames[$], exp_frames[$];
    int          eof_cnt, proto_err, abort_beat;
    int          n_pass, n_total;
    bit          gnt_en, rand_ready, rand_gap, gap, req_seen;

    // ---------------- FIFO / DMA models ----------------
    task automatic drive_fifo();
        fifo_rd_do   = (fifo_q.size() > 0) ? fifo_q[0] : 36'h0;
        fifo_empty   = (fifo_q.size() == 0) || gap;
        fifo_count   = (fifo_q.size() > 1023) ? 10'd1023 : 10'(fifo_q.size());
        fifo_eof_rdy = (eof_cnt > 0);
    endtask

    task automatic push_word(input logic [35:0] w);
        fifo_q.push_back(w);
        stim_q.push_back(w);
        if (w[34]) eof_cnt++;
    endtask

    task automatic push_frame(input int n, input bit err);
        for (int i = 0; i < n; i++)
            push_word({1'b0, (i == n - 1), (i == n - 1) && err, (i == 0), 32'($urandom)});
        drive_fifo();
    endtask

    // SOF-started words with no EOF; the next pushed frame truncates them.
    task automatic push_partial(input int n);
        for (int i = 0; i < n; i++)
            push_word({1'b0, 1'b0, 1'b0, (i == 0), 32'($urandom)});
        drive_fifo();
    endtask

    // One clock: observe at the falling edge, update models just after the rising edge.
    task automatic step();
        beat_t       b;
        frame_t      f;
        bit          pop;
        logic [35:0] w;
        @(negedge rd_clk);
        if (dma_valid && dma_ready) begin
            b.data = dma_data; b.last = dma_last; got_beats.push_back(b);
        end
        if (fifo_rd_en && dma_valid && !dma_ready) proto_err++;
        if (dma_valid && fifo_empty) proto_err++;
        if (frm_done) begin
            f.len = frm_len; f.err = frm_err; got_frames.push_back(f);
        end
        if (dma_req) req_seen = 1'b1;
        pop = fifo_rd_en;
        @(posedge rd_clk);
        #1;
        if (pop) begin
            if (fifo_q.size() == 0) proto_err++;
            else begin
                w = fifo_q.pop_front();
                if (w[34]) eof_cnt--;
            end
        end
        abort = 1'b0;
        if (dma_gnt) dma_gnt = 1'b0;
        else if (gnt_en && dma_req && ($urandom_range(0, 2) == 0)) dma_gnt = 1'b1;
        dma_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        gap       = rand_gap ? ($urandom_range(0, 3) == 0) : 1'b0;
        drive_fifo();
        if (abort_beat > 0) begin
            #1;
            if (got_beats.size() == abort_beat - 1 && dma_valid && dma_ready) begin
                abort = 1'b1;
                abort_beat = 0;
            end
        end
    endtask

    task automatic run_to_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (fifo_q.size() == 0 && got_frames.size() >= exp_frames.size()) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (4) step();
    endtask

    task automatic begin_test();
        stim_q.delete(); got_beats.delete(); exp_beats.delete();
        got_frames.delete(); exp_frames.delete();
        proto_err = 0; req_seen = 1'b0; abort_beat = 0;
    endtask

    // ---------------- reference model ----------------
    // Walks the pushed word stream frame by frame: every word of a frame is
    // counted, words are delivered until an abort or the length limit, bursts
    // end every C_BURST delivered words, and a SOF inside a delivered frame
    // closes it early.
    task automatic build_expect(input int abort_at);
        int          i, len, dlv;
        bit          err, drop, closed, ab;
        logic [35:0] w;
        beat_t       b;
        frame_t      f;
        i = 0;
        while (i < stim_q.size()) begin
            len = 0; dlv = 0; err = 0; drop = 0; closed = 0;
            while (!closed && i < stim_q.size()) begin
                w = stim_q[i];
                if (len > 0 && !drop && w[32]) begin
                    err = 1; closed = 1;
                end else begin
                    len++; i++;
                    if (!drop) begin
                        dlv++;
                        ab = (exp_beats.size() + 1 == abort_at);
                        b.data = w[31:0];
                        b.last = (dlv % C_BURST == 0) || w[34] || (dlv == C_MAX) || ab;
                        if (ab) begin err = 1; if (!w[34]) drop = 1; end
                        if (dlv == C_MAX && !w[34]) begin err = 1; drop = 1; end
                        exp_beats.push_back(b);
                    end
                    if (w[34]) begin err = err | w[33]; closed = 1; end
                end
            end
            f.len = 16'(len); f.err = err;
            exp_frames.push_back(f);
        end
    endtask

    function automatic int beat_errs();
        int e = 0;
        int n = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
        for (int i = 0; i < n; i++)
            if (got_beats[i] !== exp_beats[i]) e++;
        return e + ((got_beats.size() > n) ? got_beats.size() - n : exp_beats.size() - n);
    endfunction

    function automatic int frame_errs();
        int e = 0;
        int n = (got_frames.size() < exp_frames.size()) ? got_frames.size() : exp_frames.size();
        for (int i = 0; i < n; i++)
            if (got_frames[i] !== exp_frames[i]) e++;
        return e + ((got_frames.size() > n) ? got_frames.size() - n : exp_frames.size() - n);
    endfunction

    function automatic int n_lasts();
        int c = 0;
        for (int i = 0; i < got_beats.size(); i++) if (got_beats[i].last) c++;
        return c;
    endfunction

    function automatic logic [16:0] got_frame(input int i);
        return (i < got_frames.size()) ? {got_frames[i].len, got_frames[i].err} : 17'h1FFFF;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [53:0] outs;
        rst = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        outs = {dma_req, dma_valid, dma_last, fifo_rd_en, frm_done, frm_len, frm_err, dma_data};
        n_total++; if (outs !== 54'h0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        bit to;
        begin_test(); push_frame(5, 1'b0); build_expect(0);
        run_to_idle(200, to);
        n_total++; if (to !== 1'b0) $display("FAIL single_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (got_beats.size() !== 5) $display("FAIL single_beats: got %0d want 5", got_beats.size()); else n_pass++;
        n_total++; if (n_lasts() !== 1 || got_beats[4].last !== 1'b1) $display("FAIL single_last: got %0d lasts want 1 on w4", n_lasts()); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL single_data: got %0d bad beats want 0", beat_errs()); else n_pass++;
        n_total++; if (got_frame(0) !== {16'd5, 1'b0}) $display("FAIL single_frame: got %h want %h", got_frame(0), {16'd5, 1'b0}); else n_pass++;
    endtask

    task automatic test_multi_burst();
        bit to;
        begin_test(); push_frame(40, 1'b0); build_expect(0);
        run_to_idle(400, to);
        n_total++; if (to !== 1'b0) $display("FAIL burst_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (n_lasts() !== 3) $display("FAIL burst_lasts: got %0d want 3", n_lasts()); else n_pass++;
        n_total++; if (got_beats.size() !== 40 || !got_beats[15].last || !got_beats[31].last || !got_beats[39].last)
            $display("FAIL burst_last_pos: got %0d beats, lasts at 16/32/40 missing", got_beats.size()); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL burst_data: got %0d bad beats want 0", beat_errs()); else n_pass++;
        n_total++; if (got_frame(0) !== {16'd40, 1'b0}) $display("FAIL burst_frame: got %h want %h", got_frame(0), {16'd40, 1'b0}); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        begin_test(); rand_ready = 1'b1; rand_gap = 1'b1;
        push_frame(37, 1'b0); push_frame(9, 1'b0); build_expect(0);
        run_to_idle(2000, to);
        rand_ready = 1'b0; rand_gap = 1'b0;
        n_total++; if (to !== 1'b0) $display("FAIL bp_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL bp_order: got %0d bad beats want 0", beat_errs()); else n_pass++;
        n_total++; if (frame_errs() !== 0) $display("FAIL bp_frames: got %0d bad frames want 0", frame_errs()); else n_pass++;
        n_total++; if (proto_err !== 0) $display("FAIL bp_protocol: got %0d violations want 0", proto_err); else n_pass++;
    endtask

    task automatic test_oversize();
        bit to;
        begin_test(); push_frame(2100, 1'b0); build_expect(0);
        run_to_idle(6000, to);
        n_total++; if (to !== 1'b0) $display("FAIL over_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (got_beats.size() !== C_MAX) $display("FAIL over_beats: got %0d want %0d", got_beats.size(), C_MAX); else n_pass++;
        n_total++; if (got_beats.size() == C_MAX && got_beats[C_MAX-1].last !== 1'b1) $display("FAIL over_last: got 0 want 1"); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL over_data: got %0d bad beats want 0", beat_errs()); else n_pass++;
        n_total++; if (got_frame(0) !== {16'd2100, 1'b1}) $display("FAIL over_frame: got %h want %h", got_frame(0), {16'd2100, 1'b1}); else n_pass++;
    endtask

    task automatic test_abort();
        bit to;
        begin_test(); push_frame(10, 1'b0); build_expect(3);
        abort_beat = 3;
        run_to_idle(300, to);
        n_total++; if (to !== 1'b0) $display("FAIL abort_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (got_beats.size() !== 3) $display("FAIL abort_beats: got %0d want 3", got_beats.size()); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL abort_data_last: got %0d bad beats want 0", beat_errs()); else n_pass++;
        n_total++; if (got_frame(0) !== {16'd10, 1'b1}) $display("FAIL abort_frame: got %h want %h", got_frame(0), {16'd10, 1'b1}); else n_pass++;
    endtask

    task automatic test_err_and_sof();
        bit to;
        begin_test(); push_frame(7, 1'b1); push_partial(3); push_frame(6, 1'b0); build_expect(0);
        run_to_idle(400, to);
        n_total++; if (to !== 1'b0) $display("FAIL errsof_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (got_frame(0) !== {16'd7, 1'b1}) $display("FAIL eof_err_frame: got %h want %h", got_frame(0), {16'd7, 1'b1}); else n_pass++;
        n_total++; if (got_frame(1) !== {16'd3, 1'b1}) $display("FAIL mid_sof_frame: got %h want %h", got_frame(1), {16'd3, 1'b1}); else n_pass++;
        n_total++; if (got_frame(2) !== {16'd6, 1'b0}) $display("FAIL after_sof_frame: got %h want %h", got_frame(2), {16'd6, 1'b0}); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL errsof_data: got %0d bad beats want 0", beat_errs()); else n_pass++;
    endtask

    task automatic test_req_abort();
        bit     to;
        frame_t f;
        begin_test(); gnt_en = 1'b0; push_frame(6, 1'b0);
        f.len = 16'd6; f.err = 1'b1; exp_frames.push_back(f);
        to = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (dma_req) begin to = 1'b0; break; end
        end
        n_total++; if (to !== 1'b0) $display("FAIL reqab_no_req: got %0d want 0", to); else n_pass++;
        abort = 1'b1; dma_gnt = 1'b1;   // grant and abort in the same cycle
        step();
        gnt_en = 1'b1;
        n_total++; if (dma_req !== 1'b0) $display("FAIL reqab_req_drop: got %b want 0", dma_req); else n_pass++;
        run_to_idle(200, to);
        n_total++; if (got_beats.size() !== 0) $display("FAIL reqab_beats: got %0d want 0", got_beats.size()); else n_pass++;
        n_total++; if (got_frame(0) !== {16'd6, 1'b1}) $display("FAIL reqab_frame: got %h want %h", got_frame(0), {16'd6, 1'b1}); else n_pass++;
    endtask

    task automatic test_enable_gate();
        bit to;
        begin_test(); enable = 1'b0; push_frame(5, 1'b0);
        repeat (20) step();
        n_total++; if (req_seen !== 1'b0) $display("FAIL enable_block_req: got %b want 0", req_seen); else n_pass++;
        n_total++; if (fifo_q.size() !== 5) $display("FAIL enable_block_pop: got %0d words want 5", fifo_q.size()); else n_pass++;
        enable = 1'b1; build_expect(0);
        run_to_idle(200, to);
        n_total++; if (frame_errs() !== 0 || to !== 1'b0) $display("FAIL enable_resume: got %0d bad frames want 0", frame_errs()); else n_pass++;
    endtask

    task automatic test_random_frames();
        bit to;
        begin_test(); rand_ready = 1'b1; rand_gap = 1'b1;
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 4) == 0) push_partial($urandom_range(1, 5));
            push_frame($urandom_range(1, 60), ($urandom_range(0, 3) == 0));
        end
        build_expect(0);
        run_to_idle(8000, to);
        rand_ready = 1'b0; rand_gap = 1'b0;
        n_total++; if (to !== 1'b0) $display("FAIL rand_timeout: got %0d want 0", to); else n_pass++;
        n_total++; if (beat_errs() !== 0) $display("FAIL rand_beats: got %0d bad beats want 0", beat_errs()); else n_pass++;
        n_total++; if (frame_errs() !== 0) $display("FAIL rand_frames: got %0d bad frames want 0 (of %0d)", frame_errs(), exp_frames.size()); else n_pass++;
        n_total++; if (proto_err !== 0) $display("FAIL rand_protocol: got %0d violations want 0", proto_err); else n_pass++;
    endtask

    task automatic test_reset_mid_xfer();
        bit          to;
        logic [53:0] outs;
        begin_test(); push_frame(40, 1'b0);
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (got_beats.size() >= 2) begin to = 1'b0; break; end
        end
        n_total++; if (to !== 1'b0) $display("FAIL rstx_no_xfer: got %0d want 0", to); else n_pass++;
        rst = 1'b1;
        step();
        @(negedge rd_clk);
        outs = {dma_req, dma_valid, dma_last, fifo_rd_en, frm_done, frm_len, frm_err, dma_data};
        n_total++; if (outs !== 54'h0) $display("FAIL rstx_outputs: got %h want 0", outs); else n_pass++;
        rst = 1'b0; dma_gnt = 1'b0;
        fifo_q.delete(); eof_cnt = 0; drive_fifo();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; abort = 1'b0; dma_gnt = 1'b0; dma_ready = 1'b1;
        gnt_en = 1'b1; rand_ready = 1'b0; rand_gap = 1'b0; gap = 1'b0;
        eof_cnt = 0; proto_err = 0; abort_beat = 0; n_pass = 0; n_total = 0;
        drive_fifo();
        test_reset();
        test_single_frame();
        test_multi_burst();
        test_backpressure();
        test_oversize();
        test_abort();
        test_err_and_sof();
        test_req_abort();
        test_enable_gate();
        test_random_frames();
        test_reset_mid_xfer();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
